// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_pkt_t;

  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
  localparam logic [31:0] INSTR_BYTES = 32'd4;

  // Sequential successor of a word address, wrapping at the end of instruction memory.
  function automatic logic [31:0] next_pc(input logic [31:0] pc, input logic [31:0] mem_bytes);
    logic [31:0] sum;
    sum = (pc + INSTR_BYTES) % mem_bytes;
    return sum & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry packet FIFO between the memory response and the decode handshake.
module fetch_skid_fifo
  import fetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  fetch_pkt_t push_pkt,
  input  logic       pop,
  input  logic       flush,
  output logic [1:0] count,
  output fetch_pkt_t head
);

  fetch_pkt_t mem_q [2];
  logic       rd_ptr_q;
  logic       wr_ptr_q;
  logic [1:0] count_q;

  // Flush wins over push/pop; storage is cleared only on reset so head reads 0 afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_pkt;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, hides the 1-cycle imem latency, handles redirects.
// Optional FETCH_MISALIGN_CHK_EN adds out_fault reporting for unaligned redirect targets.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
`ifdef FETCH_MISALIGN_CHK_EN
  ,
  output logic        out_fault
`endif
);

  localparam logic [31:0] MemBytes = 32'(IMEM_WORDS * 4);

  logic [31:0] pc_next_q;
  logic        inflight_q;
  logic [31:0] inflight_pc_q;

  logic [1:0]  fifo_count;
  fetch_pkt_t  fifo_head;
  fetch_pkt_t  push_pkt;
  logic        fifo_nonempty;
  logic        fifo_push;
  logic        fifo_pop;
  logic        issue;
  logic [31:0] issue_pc;
  logic [31:0] redirect_target;
  logic        fault_redirect;
  logic        fault_active;
  logic        fault_pending;

  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
  assign fifo_nonempty   = (fifo_count != 2'd0);
  assign push_pkt        = '{pc: inflight_pc_q, instr: imem_data};

`ifdef FETCH_MISALIGN_CHK_EN
  logic        fault_q;
  logic        fault_done_q;
  logic [31:0] fault_pc_q;
  logic        fault_accept;

  assign fault_redirect = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign fault_active   = fault_q;
  assign fault_pending  = fault_q && !fault_done_q;
  assign fault_accept   = out_valid && out_ready && !fifo_nonempty && fault_pending;
  assign out_fault      = out_valid && !fifo_nonempty && fault_pending;

  // Fault is sticky until the next redirect (aligned clears it) or reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_q      <= 1'b0;
      fault_done_q <= 1'b0;
      fault_pc_q   <= 32'd0;
    end else if (redirect_valid) begin
      fault_q      <= fault_redirect;
      fault_done_q <= 1'b0;
      if (fault_redirect) begin
        fault_pc_q <= redirect_pc;
      end
    end else if (fault_accept) begin
      fault_done_q <= 1'b1;
    end
  end

  always_comb begin
    if (fifo_nonempty || !fault_pending) begin
      out_pc    = fifo_head.pc;
      out_instr = fifo_head.instr;
    end else begin
      out_pc    = fault_pc_q;
      out_instr = NOP_INSTR;
    end
  end
`else
  assign fault_redirect = 1'b0;
  assign fault_active   = 1'b0;
  assign fault_pending  = 1'b0;
  assign out_pc         = fifo_head.pc;
  assign out_instr      = fifo_head.instr;
`endif

  // Redirect beats issue and pop; the issue rule keeps one FIFO slot per in-flight request.
  always_comb begin
    out_valid = !rst && !redirect_valid && (fifo_nonempty || fault_pending);
    fifo_pop  = out_valid && out_ready && fifo_nonempty;
    fifo_push = inflight_q && !redirect_valid;
    if (redirect_valid) begin
      issue = !fault_redirect;
    end else begin
      issue = !fault_active &&
              ((({1'b0, fifo_count} + {2'b00, inflight_q}) < 3'd2) || fifo_pop);
    end
    issue    = issue && !rst;
    issue_pc = redirect_valid ? redirect_target : pc_next_q;
  end

  assign imem_en   = issue;
  assign imem_addr = issue_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_next_q     <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'd0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        inflight_pc_q <= issue_pc;
        pc_next_q     <= next_pc(issue_pc, MemBytes);
      end
    end
  end

  fetch_skid_fifo u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_pkt (push_pkt),
    .pop      (fifo_pop),
    .flush    (redirect_valid),
    .count    (fifo_count),
    .head     (fifo_head)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: per-cycle vectors plus a transfer scoreboard.
module tb_instruction_fetch;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
`ifdef FETCH_MISALIGN_CHK_EN
  logic        out_fault;
`endif

  int total = 0;
  int bad   = 0;
  logic prev_rst = 1'b0;
  logic [31:0] mem [1024];
  fetch_pkt_t exp_q [$];

  typedef struct {
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic        een;
    logic [31:0] eaddr;
  } vec_t;

  instruction_fetch #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_WORDS (1024)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_en        (imem_en),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr)
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    .out_fault      (out_fault)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous-read instruction memory model.
  always @(posedge clk) begin
    if (imem_en) imem_data <= mem[imem_addr[11:2]];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Every accepted packet must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_xfer: got pc=%h expected no transfer", out_pc);
      end else begin
        fetch_pkt_t p;
        p = exp_q.pop_front();
        chk("xfer_pc", out_pc, p.pc);
        chk("xfer_instr", out_instr, p.instr);
      end
    end
  end

  // Drive one cycle's inputs just after posedge, check outputs at negedge.
  task automatic cyc(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc,
                     input logic ev, input logic [31:0] epc, input logic een,
                     input logic [31:0] eaddr, input logic ef);
    logic [31:0] ei;
    ei = ef ? NOP_INSTR : mem[epc[11:2]];
    rst = r;
    out_ready = rdy;
    redirect_valid = rv;
    redirect_pc = rpc;
    if (ev && rdy && !r) exp_q.push_back('{pc: epc, instr: ei});
    @(negedge clk);
    chk("out_valid", {31'd0, out_valid}, {31'd0, ev});
    if (ev) begin
      chk("out_pc", out_pc, epc);
      chk("out_instr", out_instr, ei);
    end
    if (r && prev_rst) begin
      chk("rst_out_pc", out_pc, 32'd0);
      chk("rst_out_instr", out_instr, 32'd0);
    end
    chk("imem_en", {31'd0, imem_en}, {31'd0, een});
    if (een) chk("imem_addr", imem_addr, eaddr);
`ifdef FETCH_MISALIGN_CHK_EN
    chk("out_fault", {31'd0, out_fault}, {31'd0, ev & ef});
`endif
    prev_rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  vec_t stall_tab [13];

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 | i;
    mem[0] = 32'h0050_0113;
    mem[1] = 32'h0070_0193;
    mem[2] = 32'h0031_0233;
    mem[3] = 32'h0000_006F;

    // Startup latency, then stall cycles 3..8 and resume.
    stall_tab[0]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h0};
    stall_tab[1]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h4};
    stall_tab[2]  = '{1'b1, 1'b1, 32'h0,  1'b1, 32'h8};
    for (int i = 3; i <= 8; i++) stall_tab[i] = '{1'b0, 1'b1, 32'h4, 1'b0, 32'hC};
    stall_tab[9]  = '{1'b1, 1'b1, 32'h4,  1'b1, 32'hC};
    stall_tab[10] = '{1'b1, 1'b1, 32'h8,  1'b1, 32'h10};
    stall_tab[11] = '{1'b1, 1'b1, 32'hC,  1'b1, 32'h14};
    stall_tab[12] = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h18};

    rst = 1'b1;
    out_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'd0;
    @(posedge clk);
    #1;

    do_reset();
    for (int i = 0; i < 13; i++) begin
      cyc(0, stall_tab[i].rdy, 0, 0, stall_tab[i].ev, stall_tab[i].epc,
          stall_tab[i].een, stall_tab[i].eaddr, 0);
    end

    // Redirect to 0xC in cycle 5; mid-run reset also drops the pending response.
    do_reset();
    cyc(0, 1, 0, 0,     0, 0,     1, 32'h0,  0);
    cyc(0, 1, 0, 0,     0, 0,     1, 32'h4,  0);
    cyc(0, 1, 0, 0,     1, 32'h0, 1, 32'h8,  0);
    cyc(0, 1, 0, 0,     1, 32'h4, 1, 32'hC,  0);
    cyc(0, 1, 0, 0,     1, 32'h8, 1, 32'h10, 0);
    cyc(0, 1, 1, 32'hC, 0, 0,     1, 32'hC,  0);
    cyc(0, 1, 0, 0,     0, 0,     1, 32'h10, 0);
    cyc(0, 1, 0, 0,     1, 32'hC, 1, 32'h14, 0);
    cyc(0, 1, 0, 0,     1, 32'h10, 1, 32'h18, 0);

    // Back-to-back redirects, then a run across the memory wrap.
    do_reset();
    cyc(0, 1, 0, 0,       0, 0,       1, 32'h0,   0);
    cyc(0, 1, 0, 0,       0, 0,       1, 32'h4,   0);
    cyc(0, 1, 0, 0,       1, 32'h0,   1, 32'h8,   0);
    cyc(0, 1, 1, 32'h8,   0, 0,       1, 32'h8,   0);
    cyc(0, 1, 1, 32'h0,   0, 0,       1, 32'h0,   0);
    cyc(0, 1, 0, 0,       0, 0,       1, 32'h4,   0);
    cyc(0, 1, 0, 0,       1, 32'h0,   1, 32'h8,   0);
    cyc(0, 1, 0, 0,       1, 32'h4,   1, 32'hC,   0);
    cyc(0, 1, 1, 32'hFF8, 0, 0,       1, 32'hFF8, 0);
    cyc(0, 1, 0, 0,       0, 0,       1, 32'hFFC, 0);
    cyc(0, 1, 0, 0,       1, 32'hFF8, 1, 32'h0,   0);
    cyc(0, 1, 0, 0,       1, 32'hFFC, 1, 32'h4,   0);
    cyc(0, 1, 0, 0,       1, 32'h0,   1, 32'h8,   0);

`ifdef FETCH_MISALIGN_CHK_EN
    // Unaligned redirect: one NOP fault packet, no issue until an aligned redirect.
    do_reset();
    cyc(0, 1, 0, 0,     0, 0,     1, 32'h0,  0);
    cyc(0, 1, 0, 0,     0, 0,     1, 32'h4,  0);
    cyc(0, 1, 0, 0,     1, 32'h0, 1, 32'h8,  0);
    cyc(0, 1, 1, 32'h6, 0, 0,     0, 0,      0);
    cyc(0, 1, 0, 0,     1, 32'h6, 0, 0,      1);
    cyc(0, 1, 0, 0,     0, 0,     0, 0,      0);
    cyc(0, 1, 0, 0,     0, 0,     0, 0,      0);
    cyc(0, 1, 1, 32'h8, 0, 0,     1, 32'h8,  0);
    cyc(0, 1, 0, 0,     0, 0,     1, 32'hC,  0);
    cyc(0, 1, 0, 0,     1, 32'h8, 1, 32'h10, 0);
`else
    // Unaligned redirect target has its low bits dropped.
    cyc(0, 1, 1, 32'h6, 0, 0,     1, 32'h4, 0);
    cyc(0, 1, 0, 0,     0, 0,     1, 32'h8, 0);
    cyc(0, 1, 0, 0,     1, 32'h4, 1, 32'hC, 0);
`endif

    out_ready = 1'b0;
    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Fetch stage directly downstream of the instruction memory read port. Owns the PC and drives the memory's read enable and byte address. Absorbs the memory's fixed 1-cycle read latency and presents {pc, instr} packets to decode over a valid/ready handshake. Accepts PC redirects from execute (jumps, branches) and flushes stale fetches.

Parameters:
RESET_PC, 32'h0000_0000, byte address of the first fetch after reset
IMEM_WORDS, 1024, instruction memory depth in words; the PC wraps modulo IMEM_WORDS*4

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous active-high reset
imem_en  out  1  read enable to instruction memory port A
imem_addr  out  32  byte address to port A; bits [1:0] always 0
imem_data  in  32  port A read data, valid the cycle after imem_en=1
redirect_valid  in  1  single-cycle PC override request from execute
redirect_pc  in  32  target byte address for the redirect
out_valid  out  1  packet available to decode
out_ready  in  1  decode accepts the packet
out_pc  out  32  byte PC of out_instr
out_instr  out  32  fetched instruction word

Behaviour:
- Reset (rst=1 at an edge): pc_next=RESET_PC, FIFO empty, inflight=0, out_valid=0, out_pc=0, out_instr=0, imem_en=0 during the reset cycle.
- Internal state: pc_next (next address to issue); inflight flag (request issued last cycle, data on imem_data now) with the request's PC; 2-entry packet FIFO feeding the out_* ports.
- Issue rule: imem_en=1 when (FIFO count + inflight) < 2, or when a FIFO entry pops this cycle. On issue, imem_addr=pc_next and pc_next advances by 4.
- Response: when inflight=1, {inflight_pc, imem_data} is written into the FIFO at the next edge.
- Latency: the request issued in cycle N appears on out_* in cycle N+2. The first packet after reset release is at cycle 2. Steady-state throughput is 1 packet per cycle with out_ready held high.
- Handshake: the packet transfers when out_valid && out_ready. While out_valid=1 and out_ready=0, out_pc and out_instr are held stable. The FIFO never overflows because the issue rule reserves a slot for every in-flight request.
- Stall: with out_ready=0 the FIFO fills to 2, imem_en drops to 0, and pc_next freezes.
- Redirect in cycle N:
  - out_valid is forced to 0 in cycle N, so no transfer occurs.
  - The FIFO is cleared at the end of cycle N.
  - The response arriving in cycle N+1 from the pre-redirect request is discarded.
  - imem_addr=redirect_pc with imem_en=1 in cycle N, bypassing pc_next; pc_next becomes redirect_pc+4.
  - The target packet appears at N+2.
- Redirect while stalled or empty: same rules apply; redirect always has priority over issue and pop.
- Back-to-back redirects: the last one wins. Each cycle's redirect discards all earlier work.
- Address arithmetic: 32-bit add, then pc_next[1:0] forced to 0. At IMEM_WORDS*4-4 the next address wraps to 0.
- rst asserted mid-operation: behaves as the reset above on that edge. The pending response is discarded.

Optional Feature:
Macro FETCH_MISALIGN_CHK_EN.
- With it defined:
  - Adds output out_fault (1 bit, reset 0).
  - A redirect with redirect_pc[1:0]!=0 sets sticky fault state and stops issue (imem_en=0).
  - After draining the FIFO, one packet is presented with out_fault=1, out_pc=redirect_pc (unaligned), and out_instr=32'h0000_0013 (nop).
  - Only a later aligned redirect or rst clears the fault state.
- Without it: no out_fault port; redirect_pc[1:0] are silently zeroed.

Decomposition:
- Package fetch_pkg holds:
  - typedef fetch_pkt_t {pc[31:0], instr[31:0]}
  - constants NOP_INSTR=32'h0000_0013 and INSTR_BYTES=4
- One sub-module, fetch_skid_fifo: 2-entry FIFO of fetch_pkt_t with push, pop, flush, count, and head outputs.
- PC logic, issue logic and redirect logic stay in instruction_fetch.

Test Plan:
1. Memory words 0..3 = 00500113, 00700193, 00310233, 0000006F; release rst, out_ready=1 → packets (0x0,00500113) at cycle 2, then (0x4,...), (0x8,...), (0xC,0000006F) on consecutive cycles.
2. out_ready=0 for cycles 3-8 → out holds (0x4,00700193), imem_en=0 after the FIFO fills; on release the sequence resumes 0x8, 0xC with no duplicates or gaps.
3. redirect_valid=1 with redirect_pc=0xC in cycle 5 → no transfer in cycle 5; next out_pc=0xC at cycle 7, then 0x10; the stale in-flight packet is never seen.
4. Redirects to 0x8 and then 0x0 in consecutive cycles → first packet is out_pc=0x0, two cycles after the second redirect.
5. Run past 0xFFC with IMEM_WORDS=1024 → out_pc sequence 0xFF8, 0xFFC, 0x000.
6. With FETCH_MISALIGN_CHK_EN, redirect_pc=0x6 → out_fault=1, out_pc=0x6, out_instr=00000013, imem_en=0 until a redirect to 0x8, after which fetch resumes normally.
